// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue controller for the 16-bit lab ALU. Accepts one instruction
//            at a time, reads operands from a 16x16 register file, drives the
//            external combinational ALU and writes the result back.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  input  logic [15:0]             instr,
  output logic                    instr_ready,
  output logic [2:0]              alu_op,
  output logic [3:0]              alu_imm,
  output logic [DW-1:0]           alu_a,
  output logic [DW-1:0]           alu_b,
  input  logic [DW-1:0]           alu_out,
  output logic                    wb_valid,
  output logic [$clog2(NREG)-1:0] wb_addr,
  output logic [DW-1:0]           wb_data,
  output logic                    illegal,
  output logic                    busy,
  input  logic [$clog2(NREG)-1:0] dbg_addr,
  output logic [DW-1:0]           dbg_data
);

  localparam int c_AW = $clog2(NREG);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          r_state;
  logic [15:0]     r_instr;
  logic [DW-1:0]   r_result;
  logic [DW-1:0]   r_rf [NREG];

  // Field decode of the latched instruction.
  logic [3:0]      w_opc;
  logic [c_AW-1:0] w_rd;
  logic [c_AW-1:0] w_rs;
  logic [c_AW-1:0] w_rt;
  logic [DW-1:0]   w_imm8;
  logic            w_is_ldi;
  logic            w_uses_rt;
  logic            w_in_illegal;
  logic [DW-1:0]   w_exec_result;

  assign w_opc     = r_instr[15:12];
  assign w_rd      = r_instr[8 +: c_AW];
  assign w_rs      = r_instr[4 +: c_AW];
  assign w_rt      = r_instr[0 +: c_AW];
  assign w_imm8    = {{(DW-8){1'b0}}, r_instr[7:0]};
  assign w_is_ldi  = (w_opc == 4'd8);
  assign w_uses_rt = (w_opc[3:2] == 2'b00);

  // Illegal opcodes (9..15) are flagged at accept so the pulse lands in READ.
  assign w_in_illegal = instr[15] && (instr[14:12] != 3'd0);

  assign w_exec_result = w_is_ldi ? w_imm8 : alu_out;

  // R0 is hardwired to zero on the read side as well.
  assign dbg_data = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_result    <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      alu_op      <= '0;
      alu_imm     <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= '0;
      end
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr     <= instr;
            illegal     <= w_in_illegal;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          if (w_opc[3] && !w_is_ldi) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            alu_a   <= r_rf[w_rs];
            alu_b   <= w_uses_rt ? r_rf[w_rt] : '0;
            alu_op  <= w_opc[2:0];
            alu_imm <= r_instr[3:0];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Result and write-back outputs are loaded together so WB sees them at once.
          r_result <= w_exec_result;
          wb_valid <= 1'b1;
          wb_addr  <= w_rd;
          wb_data  <= w_exec_result;
          r_state  <= S_WB;
        end
        S_WB: begin
          if (w_rd != '0) begin
            r_rf[w_rd] <= r_result;
          end
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Purpose  : Scoreboard bench for alu_issue_ctrl with a behavioural ALU model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  alu_op;
  logic [3:0]  alu_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal;
  logic        busy;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue_ctrl #(.DW(16), .NREG(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_imm(alu_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .illegal(illegal), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU.
  logic [31:0] w_rot;
  always_comb begin
    w_rot   = {alu_a, alu_a} << alu_imm;
    alu_out = 16'h0000;
    case (alu_op)
      3'd0: alu_out = alu_a + alu_b;
      3'd1: alu_out = alu_a - alu_b;
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = alu_a << alu_imm;
      3'd5: alu_out = alu_a >> alu_imm;
      3'd6: alu_out = $signed(alu_a) >>> alu_imm;
      3'd7: alu_out = w_rot[31:16];
      default: alu_out = 16'h0000;
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ill;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation per write-back or illegal pulse.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || illegal)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: wb_valid=%0b illegal=%0b with empty scoreboard", wb_valid, illegal);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.ill) begin
          if (!illegal || wb_valid) begin
            failures++;
            $display("FAIL sb_illegal: illegal=%0b wb_valid=%0b expected illegal only", illegal, wb_valid);
          end
        end else if (!wb_valid || illegal || wb_addr !== e.addr || wb_data !== e.data) begin
          failures++;
          $display("FAIL sb_wb: addr=%0d data=0x%04h ill=%0b expected addr=%0d data=0x%04h",
                   wb_addr, wb_data, illegal, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_exp(input bit ill, input logic [3:0] addr, input logic [15:0] data);
    exp_t e;
    e.ill  = ill;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: instr_ready=%0b expected 1", instr_ready);
    end
  endtask

  // Drive one instruction until it is accepted, then drop instr_valid.
  task automatic send(input logic [15:0] ins, input bit ill, input logic [15:0] data);
    wait_ready();
    instr       = ins;
    instr_valid = 1'b1;
    push_exp(ill, ins[11:8], data);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  int acc [3];

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    dbg_addr    = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_ready", {15'd0, instr_ready}, 16'h0001);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_wb_valid", {15'd0, wb_valid}, 16'h0000);
    chk("rst_alu_a", alu_a, 16'h0000);
    dbg_addr = 4'd5;
    #1 chk("rst_rf5", dbg_data, 16'h0000);
    rst_n = 1'b1;

    // 1: LDI, LDI, ADD with latency check
    send(16'h8105, 1'b0, 16'h0005);
    send(16'h8203, 1'b0, 16'h0003);
    send(16'h0312, 1'b0, 16'h0008);
    @(negedge clk); chk("lat_read_wb", {15'd0, wb_valid}, 16'h0000);
    chk("lat_read_busy", {15'd0, busy}, 16'h0001);
    @(negedge clk); chk("lat_exec_wb", {15'd0, wb_valid}, 16'h0000);
    @(negedge clk); chk("lat_wb_valid", {15'd0, wb_valid}, 16'h0001);
    dbg_addr = 4'd3;
    #1 chk("wb_old_value", dbg_data, 16'h0000);

    // 2: SUB wraps, OR
    send(16'h1421, 1'b0, 16'hFFFE);
    send(16'h3812, 1'b0, 16'h0007);

    // 3: shifts and rotate
    send(16'h8580, 1'b0, 16'h0080);
    send(16'h4558, 1'b0, 16'h8000);
    send(16'h6654, 1'b0, 16'hF800);
    send(16'h5954, 1'b0, 16'h0800);
    send(16'h7751, 1'b0, 16'h0001);

    // 4: write to R0 pulses but is suppressed
    send(16'h0012, 1'b0, 16'h0008);
    // 5: illegal opcode
    send(16'hF123, 1'b1, 16'h0000);
    wait_ready();
    chk("ill_idle_busy", {15'd0, busy}, 16'h0000);
    dbg_addr = 4'd0; #1 chk("rf0", dbg_data, 16'h0000);
    dbg_addr = 4'd1; #1 chk("rf1", dbg_data, 16'h0005);
    dbg_addr = 4'd3; #1 chk("rf3", dbg_data, 16'h0008);
    dbg_addr = 4'd4; #1 chk("rf4", dbg_data, 16'hFFFE);
    dbg_addr = 4'd5; #1 chk("rf5", dbg_data, 16'h8000);
    dbg_addr = 4'd6; #1 chk("rf6", dbg_data, 16'hF800);
    dbg_addr = 4'd7; #1 chk("rf7", dbg_data, 16'h0001);
    dbg_addr = 4'd8; #1 chk("rf8", dbg_data, 16'h0007);
    dbg_addr = 4'd9; #1 chk("rf9", dbg_data, 16'h0800);

    // 6a: instr_valid held high, back-to-back accepts every 4 cycles
    instr       = 16'h0A12;
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ready();
      acc[k] = cyc;
      case (k)
        0: push_exp(1'b0, 4'd10, 16'h0008);
        1: push_exp(1'b0, 4'd11, 16'h0002);
        default: push_exp(1'b0, 4'd12, 16'h0001);
      endcase
      @(posedge clk);
      #1;
      if (k == 0) instr = 16'h1B12;
      else if (k == 1) instr = 16'h2C12;
    end
    instr_valid = 1'b0;
    chk("b2b_gap1", 16'(acc[1] - acc[0]), 16'd4);
    chk("b2b_gap2", 16'(acc[2] - acc[1]), 16'd4);
    wait_ready();
    dbg_addr = 4'd12; #1 chk("rf12", dbg_data, 16'h0001);

    // 6b: reset during EXEC drops the instruction
    wait_ready();
    instr       = 16'h1312;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {15'd0, instr_ready}, 16'h0001);
    chk("mid_rst_wb", {15'd0, wb_valid}, 16'h0000);
    chk("mid_rst_busy", {15'd0, busy}, 16'h0000);
    dbg_addr = 4'd3; #1 chk("mid_rst_rf3", dbg_data, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_wb", {15'd0, wb_valid}, 16'h0000);

    // Normal operation after reset
    send(16'h8342, 1'b0, 16'h0042);
    wait_ready();
    dbg_addr = 4'd3; #1 chk("post_rst_rf3", dbg_data, 16'h0042);

    repeat (4) @(negedge clk);
    chk("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
